// File: rtl/net_inject_sched_pkg.sv
// rtl/net_inject_sched_pkg.sv - shared network header type and terminal constants
package net_inject_sched_pkg;

   localparam int NET_NODE_NBITS    = 2;
   localparam int NET_OPAQUE_NBITS  = 8;
   localparam int NET_NREQS         = 4;
   localparam int NET_REQ_ID_NBITS  = $clog2(NET_NREQS);

   // Header presented to router in1; opaque carries {requester id, sequence}.
   typedef struct packed {
      logic [NET_NODE_NBITS-1:0]   dest;
      logic [NET_NODE_NBITS-1:0]   src;
      logic [NET_OPAQUE_NBITS-1:0] opaque;
   } net_hdr_t;

endpackage

// File: rtl/net_rr_arb.sv
// rtl/net_rr_arb.sv - round-robin arbiter with registered priority pointer
module net_rr_arb #(
   parameter int p_n = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [p_n-1:0] req_i,
   input  logic           en_i,
   input  logic           upd_i,
   output logic [p_n-1:0] gnt_o
);

   localparam int c_id_nbits = $clog2(p_n);

   logic [c_id_nbits-1:0] ptr_q;
   logic [c_id_nbits-1:0] ptr_d;
   logic [c_id_nbits-1:0] win_id;
   logic [c_id_nbits-1:0] idx;
   logic                  found;

   // Scan from the pointer (wrapping by truncation); first requester found wins.
   always_comb begin
      gnt_o  = '0;
      win_id = '0;
      idx    = '0;
      found  = 1'b0;
      for (int k = 0; k < p_n; k++) begin
         idx = ptr_q + c_id_nbits'(k);
         if (en_i && !found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            win_id     = idx;
            found      = 1'b1;
         end
      end
      ptr_d = ptr_q;
      if (upd_i && found) begin
         ptr_d = win_id + c_id_nbits'(1);
      end
   end

   // Pointer moves just past the winner only when a grant is accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/net_inject_sched.sv
// rtl/net_inject_sched.sv - ring terminal injection scheduler with per-requester credits
module net_inject_sched
   import net_inject_sched_pkg::*;
#(
   parameter int p_payload_nbits   = 32,
   parameter int p_nreqs           = NET_NREQS,
   parameter int p_max_outstanding = 4,
   parameter int p_opaque_nbits    = NET_OPAQUE_NBITS
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [1:0]                           router_id,
   input  logic [p_nreqs-1:0]                   req_val,
   output logic [p_nreqs-1:0]                   req_rdy,
   input  logic [2*p_nreqs-1:0]                 req_dest,
   input  logic [p_nreqs*p_payload_nbits-1:0]   req_payload,
   output net_hdr_t                             out_msg_hdr,
   output logic [p_payload_nbits-1:0]           out_msg_payload,
   output logic                                 out_val,
   input  logic                                 out_rdy,
   input  logic                                 cred_val,
   input  logic [$clog2(p_nreqs)-1:0]           cred_id
);

   localparam int c_id_nbits  = $clog2(p_nreqs);
   localparam int c_seq_nbits = p_opaque_nbits - c_id_nbits;
   localparam int c_cnt_nbits = $clog2(p_max_outstanding + 1);

   logic [c_cnt_nbits-1:0]     outst_q [p_nreqs];
   logic [c_cnt_nbits-1:0]     outst_d [p_nreqs];
   logic [c_seq_nbits-1:0]     seq_q   [p_nreqs];
   logic [c_seq_nbits-1:0]     seq_d   [p_nreqs];
   net_hdr_t                   hdr_q, hdr_d;
   logic [p_payload_nbits-1:0] payload_q, payload_d;
   logic                       val_q, val_d;

   logic                       free;
   logic                       accept;
   logic [p_nreqs-1:0]         eligible;
   logic [p_nreqs-1:0]         gnt;
   logic [c_id_nbits-1:0]      sel_id;
   logic [1:0]                 sel_dest;
   logic [p_payload_nbits-1:0] sel_payload;
   logic                       dec;

   // Output slot is free when empty or draining this cycle; requesters at their limit sit out.
   always_comb begin
      free = !val_q || out_rdy;
      for (int i = 0; i < p_nreqs; i++) begin
         eligible[i] = req_val[i] && (outst_q[i] < c_cnt_nbits'(p_max_outstanding));
      end
   end

   // Grants are suppressed during reset so nothing is handed out while state clears.
   net_rr_arb #(.p_n(p_nreqs)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req_i (eligible),
      .en_i  (free && !reset),
      .upd_i (accept),
      .gnt_o (gnt)
   );

   assign req_rdy         = gnt;
   assign accept          = |gnt;
   assign out_msg_hdr     = hdr_q;
   assign out_msg_payload = payload_q;
   assign out_val         = val_q;

   // Build the next output entry from the winner and update per-requester counters.
   always_comb begin
      sel_id      = '0;
      sel_dest    = '0;
      sel_payload = '0;
      dec         = 1'b0;
      for (int i = 0; i < p_nreqs; i++) begin
         if (gnt[i]) begin
            sel_id      = c_id_nbits'(i);
            sel_dest    = req_dest[2*i +: 2];
            sel_payload = req_payload[i*p_payload_nbits +: p_payload_nbits];
         end
      end

      val_d     = val_q;
      hdr_d     = hdr_q;
      payload_d = payload_q;
      if (free) begin
         val_d = accept;
         if (accept) begin
            hdr_d.dest   = sel_dest;
            hdr_d.src    = router_id;
            hdr_d.opaque = {sel_id, seq_q[sel_id]};
            payload_d    = sel_payload;
         end
      end

      for (int i = 0; i < p_nreqs; i++) begin
         seq_d[i]   = seq_q[i];
         outst_d[i] = outst_q[i];
         // A credit against an empty counter is spurious and dropped.
         dec = cred_val && (cred_id == c_id_nbits'(i)) && (outst_q[i] != '0);
         if (gnt[i]) begin
            seq_d[i] = seq_q[i] + c_seq_nbits'(1);
         end
         if (gnt[i] && !dec) begin
            outst_d[i] = outst_q[i] + c_cnt_nbits'(1);
         end else if (!gnt[i] && dec) begin
            outst_d[i] = outst_q[i] - c_cnt_nbits'(1);
         end
      end
   end

   // State registers; reset drops any held message and wins over same-cycle events.
   always_ff @(posedge clk) begin
      if (reset) begin
         val_q     <= 1'b0;
         hdr_q     <= '0;
         payload_q <= '0;
         for (int i = 0; i < p_nreqs; i++) begin
            outst_q[i] <= '0;
            seq_q[i]   <= '0;
         end
      end else begin
         val_q     <= val_d;
         hdr_q     <= hdr_d;
         payload_q <= payload_d;
         for (int i = 0; i < p_nreqs; i++) begin
            outst_q[i] <= outst_d[i];
            seq_q[i]   <= seq_d[i];
         end
      end
   end

endmodule

// File: tb/tb_net_inject_sched.sv
// tb/tb_net_inject_sched.sv - directed self-checking bench for net_inject_sched
module tb_net_inject_sched;
   import net_inject_sched_pkg::*;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   router_id;
   logic [3:0]   req_val;
   logic [3:0]   req_rdy;
   logic [7:0]   req_dest;
   logic [127:0] req_payload;
   net_hdr_t     out_msg_hdr;
   logic [31:0]  out_msg_payload;
   logic         out_val;
   logic         out_rdy;
   logic         cred_val;
   logic [1:0]   cred_id;

   int n_tests = 0;
   int n_fail  = 0;

   net_inject_sched dut (
      .clk             (clk),
      .reset           (reset),
      .router_id       (router_id),
      .req_val         (req_val),
      .req_rdy         (req_rdy),
      .req_dest        (req_dest),
      .req_payload     (req_payload),
      .out_msg_hdr     (out_msg_hdr),
      .out_msg_payload (out_msg_payload),
      .out_val         (out_val),
      .out_rdy         (out_rdy),
      .cred_val        (cred_val),
      .cred_id         (cred_id)
   );

   always #5 clk = ~clk;

   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check_msg(input string tag, input logic [1:0] dest, input logic [7:0] opq,
                            input logic [31:0] pay);
      check({tag, ".val"}, {63'd0, out_val}, 64'd1);
      check({tag, ".dest"}, {62'd0, out_msg_hdr.dest}, {62'd0, dest});
      check({tag, ".src"}, {62'd0, out_msg_hdr.src}, 64'd1);
      check({tag, ".opaque"}, {56'd0, out_msg_hdr.opaque}, {56'd0, opq});
      check({tag, ".payload"}, {32'd0, out_msg_payload}, {32'd0, pay});
   endtask

   logic [7:0] exp_op [5];

   initial begin
      exp_op[0] = 8'h00; exp_op[1] = 8'h40; exp_op[2] = 8'h80;
      exp_op[3] = 8'hC0; exp_op[4] = 8'h01;

      reset = 1'b1; router_id = 2'd1; req_val = 4'hF; req_dest = 8'h00;
      req_payload = '0; out_rdy = 1'b1; cred_val = 1'b0; cred_id = 2'd0;
      step(); step();
      settle();
      check("reset_rdy", {60'd0, req_rdy}, 64'h0);
      check("reset_val", {63'd0, out_val}, 64'd0);

      // single requester
      reset = 1'b0; req_val = 4'b0100; req_dest = 8'h30;
      req_payload[95:64] = 32'hA5A5_0002;
      settle();
      check("single_rdy", {60'd0, req_rdy}, 64'b0100);
      step();
      check_msg("single_m0", 2'd3, 8'h80, 32'hA5A5_0002);
      step();
      check_msg("single_m1", 2'd3, 8'h81, 32'hA5A5_0002);

      // reset mid-operation with a held message and nonzero counters
      reset = 1'b1; req_val = 4'hF; cred_val = 1'b1;
      settle();
      check("midreset_rdy", {60'd0, req_rdy}, 64'h0);
      step();
      check("midreset_val", {63'd0, out_val}, 64'd0);

      // fairness: grants 0,1,2,3,0, out_val continuously high
      reset = 1'b0; cred_val = 1'b0; req_dest = 8'hE4;
      for (int i = 0; i < 4; i++) req_payload[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
      for (int k = 0; k < 5; k++) begin
         settle();
         check($sformatf("fair_gnt%0d", k), {60'd0, req_rdy}, 64'd1 << (k % 4));
         step();
         check_msg($sformatf("fair_m%0d", k), 2'(k % 4), exp_op[k], 32'hC0DE_0000 + 32'(k % 4));
      end
      req_val = 4'b0000;
      step();
      check("fair_drain", {63'd0, out_val}, 64'd0);

      // backpressure: hold for 5 cycles, then drain and refill together
      req_val = 4'b1000; out_rdy = 1'b0; req_payload[127:96] = 32'h3333_0001;
      settle();
      check("bp_rdy_empty", {60'd0, req_rdy}, 64'b1000);
      step();
      check_msg("bp_load", 2'd3, 8'hC1, 32'h3333_0001);
      req_payload[127:96] = 32'h3333_0002;
      for (int k = 0; k < 5; k++) begin
         settle();
         check($sformatf("bp_rdy%0d", k), {60'd0, req_rdy}, 64'h0);
         check($sformatf("bp_hold%0d", k), {20'd0, out_val, out_msg_hdr, out_msg_payload},
               {20'd0, 1'b1, 2'd3, 2'd1, 8'hC1, 32'h3333_0001});
         step();
      end
      out_rdy = 1'b1;
      settle();
      check("bp_refill_rdy", {60'd0, req_rdy}, 64'b1000);
      step();
      check_msg("bp_refill", 2'd3, 8'hC2, 32'h3333_0002);
      req_val = 4'b0000;
      step();

      // credit limit on requester 1 (already holds one outstanding)
      req_val = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         settle();
         check($sformatf("lim_gnt%0d", k), {60'd0, req_rdy}, 64'b0010);
         step();
      end
      settle();
      check("lim_block", {60'd0, req_rdy}, 64'h0);
      check("lim_last_op", {56'd0, out_msg_hdr.opaque}, 64'h43);
      req_val = 4'b0011;
      settle();
      check("lim_other", {60'd0, req_rdy}, 64'b0001);
      step();
      check("lim_other_op", {56'd0, out_msg_hdr.opaque}, 64'h02);
      req_val = 4'b0010; cred_val = 1'b1; cred_id = 2'd1;
      settle();
      check("cred_same_cycle", {60'd0, req_rdy}, 64'h0);
      step();
      cred_val = 1'b0;
      settle();
      check("cred_next_cycle", {60'd0, req_rdy}, 64'b0010);
      step();
      check("cred_msg_op", {56'd0, out_msg_hdr.opaque}, 64'h44);

      // requester 0 at 3: accept plus credit leaves it at 3
      req_val = 4'b0001; cred_val = 1'b1; cred_id = 2'd0;
      settle();
      check("both_gnt", {60'd0, req_rdy}, 64'b0001);
      step();
      cred_val = 1'b0;
      check("both_op", {56'd0, out_msg_hdr.opaque}, 64'h03);
      settle();
      check("both_one_left", {60'd0, req_rdy}, 64'b0001);
      step();
      settle();
      check("both_now_full", {60'd0, req_rdy}, 64'h0);

      // requester 2: one credit empties it, a second must not underflow
      req_val = 4'b0000; cred_val = 1'b1; cred_id = 2'd2;
      step(); step();
      cred_val = 1'b0; req_val = 4'b0100;
      for (int k = 0; k < 4; k++) begin
         settle();
         check($sformatf("sat_gnt%0d", k), {60'd0, req_rdy}, 64'b0100);
         step();
      end
      settle();
      check("sat_block", {60'd0, req_rdy}, 64'h0);
      check("sat_last_op", {56'd0, out_msg_hdr.opaque}, 64'h84);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
